solver_load_sequencer: RTL
==========================

# solver_load_sequencer

Run sequencer for the WalkSAT core: on command it clears the variable table, streams a clause list into the clause table, pulses the solver start, then watches solver completion against a cycle budget. It replaces the manual force/poke initialization and the timeout loop, sitting between the host-side clause stream and the solver top's variable-table and clause-table write ports. It reports a single-cycle completion with SAT or timeout status.

## Interface
- NSAT, 3, literals per clause
- NUM_VARIABLES, 2048, variable-table entries cleared per run
- NUM_CLAUSES, 2048, clause-table capacity
- TIMEOUT_CYCLES, 10000, maximum RUN cycles before giving up
- Derived: VAW = $clog2(NUM_VARIABLES); CAW = $clog2(NUM_CLAUSES); CLAUSE_WIDTH = NSAT*8; TCW = $clog2(TIMEOUT_CYCLES+1)
- clk_i  in  1  single clock, all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- cmd_start_i  in  1  begin a run; sampled only in IDLE
- abort_i  in  1  synchronous abort, any state -> IDLE
- clause_valid_i  in  1  clause stream valid
- clause_data_i  in  CLAUSE_WIDTH  clause; bit 8k+7 is the negation bit, bits 8k+6:8k are the variable index
- clause_last_i  in  1  marks the final clause of the problem
- clause_ready_o  out  1  clause stream ready
- vt_en_o, vt_wr_en_o  out  1 each  variable-table enable and write
- vt_addr_o  out  VAW  variable-table write address
- vt_data_o  out  1  write data, constant 0
- ct_wr_en_o  out  1  clause-table write strobe
- ct_wr_addr_o  out  CAW  clause-table write address
- ct_wr_clause_o  out  CLAUSE_WIDTH  clause-table write data
- solver_start_o  out  1  one-cycle start pulse to the solver
- solver_done_i  in  1  solver reports all clauses satisfied
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle completion pulse
- sat_o, timeout_o, overflow_o  out  1 each  result flags, valid from done_o until the next cmd_start_i
- num_clauses_o  out  CAW+1  clauses loaded in the last run
- cycle_count_o  out  TCW  RUN cycles consumed in the last run

## Operation
- States: IDLE, CLEAR_VT, LOAD_CT, START, RUN, FINISH.
- IDLE: all strobes 0. cmd_start_i=1 clears the result flags and counters, then -> CLEAR_VT.
- CLEAR_VT: vt_en_o = vt_wr_en_o = 1; vt_addr_o counts 0..NUM_VARIABLES-1, one address per cycle; vt_data_o = 0. After address NUM_VARIABLES-1 -> LOAD_CT.
- LOAD_CT: clause_ready_o = 1. On each valid&ready cycle the clause is registered:
  - ct_wr_en_o = 1 on the next cycle, with ct_wr_addr_o = index and ct_wr_clause_o = data.
  - Then index increments.
- LOAD_CT exits:
  - Handshake with clause_last_i=1: num_clauses_o = index+1, -> START.
  - Handshake at index NUM_CLAUSES-1 with clause_last_i=0: that clause is still written; overflow_o = 1, -> FINISH (solver not started).
- START: solver_start_o = 1 for exactly one cycle, then -> RUN.
- RUN: cycle_count_o increments each cycle.
  - solver_done_i=1: sat_o = 1, -> FINISH.
  - cycle_count_o reaching TIMEOUT_CYCLES: timeout_o = 1, -> FINISH.
  - Both in the same cycle: sat_o wins and timeout_o stays 0.
- FINISH: done_o = 1 for one cycle, -> IDLE.
- abort_i, in any state: -> IDLE next cycle. All strobes drop, no done_o, flags hold their current values. abort_i has priority over cmd_start_i.
- cmd_start_i outside IDLE is ignored.

## Timing
- Reset values: all outputs 0; state IDLE.
- rst_i asserted mid-run behaves as abort_i and also clears all flags and counters.
- Every output is registered, driven as a Moore function of state plus the datapath registers.
- cmd_start_i sampled at edge T: vt_wr_en_o is high for cycles T+1 through T+NUM_VARIABLES; clause_ready_o rises at T+NUM_VARIABLES+1.
- Clause handshake at edge H: matching ct_wr_en_o cycle is H+1. Back-to-back handshakes give consecutive write cycles with no bubble.
- The last handshake at edge L puts solver_start_o at cycle L+2, trailing the final ct write by one cycle.
- solver_done_i sampled at edge D: done_o is high at cycle D+2 (FINISH).
- Timeout: done_o fires TIMEOUT_CYCLES+2 cycles after solver_start_o rises.
- Counters never wrap: the index saturates at NUM_CLAUSES-1 and cycle_count_o stops at TIMEOUT_CYCLES.

## Test plan
Bench parameters: NUM_VARIABLES=8, NUM_CLAUSES=4, TIMEOUT_CYCLES=20.
- Reset, then cmd_start_i: addresses 0..7 written with data 0 over exactly 8 cycles, then clause_ready_o=1, busy_o=1.
- Stream 3 clauses 0x058207, 0x860381, 0x028704, with last on the third -> ct writes at addresses 0,1,2 with matching data; num_clauses_o=3; one solver_start_o pulse.
- After load, assert solver_done_i 5 cycles after start -> done_o pulse, sat_o=1, timeout_o=0, cycle_count_o=5.
- Hold solver_done_i=0 -> done_o exactly 22 cycles after solver_start_o; timeout_o=1, cycle_count_o=20.
- Stream 4 clauses with no last -> 4 writes, overflow_o=1, done_o pulse, solver_start_o never asserted.
- abort_i during CLEAR_VT at address 3 -> next cycle IDLE, vt_wr_en_o=0, no done_o. A following cmd_start_i restarts cleanly from address 0.

Source files
------------

// File: rtl/solver_load_sequencer.sv
// rtl/solver_load_sequencer.sv - clears the variable table, loads clauses, starts the solver and times it
module solver_load_sequencer #(
  parameter int NSAT           = 3,
  parameter int NUM_VARIABLES  = 2048,
  parameter int NUM_CLAUSES    = 2048,
  parameter int TIMEOUT_CYCLES = 10000,
  localparam int VAW           = $clog2(NUM_VARIABLES),
  localparam int CAW           = $clog2(NUM_CLAUSES),
  localparam int CLAUSE_WIDTH  = NSAT * 8,
  localparam int TCW           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_start_i,
  input  logic                    abort_i,
  input  logic                    clause_valid_i,
  input  logic [CLAUSE_WIDTH-1:0] clause_data_i,
  input  logic                    clause_last_i,
  output logic                    clause_ready_o,
  output logic                    vt_en_o,
  output logic                    vt_wr_en_o,
  output logic [VAW-1:0]          vt_addr_o,
  output logic                    vt_data_o,
  output logic                    ct_wr_en_o,
  output logic [CAW-1:0]          ct_wr_addr_o,
  output logic [CLAUSE_WIDTH-1:0] ct_wr_clause_o,
  output logic                    solver_start_o,
  input  logic                    solver_done_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    sat_o,
  output logic                    timeout_o,
  output logic                    overflow_o,
  output logic [CAW:0]            num_clauses_o,
  output logic [TCW-1:0]          cycle_count_o
);

  typedef enum logic [2:0] {IDLE, CLEAR_VT, LOAD_CT, START, RUN, FINISH} state_t;

  localparam logic [VAW-1:0] VT_LAST = VAW'(NUM_VARIABLES - 1);
  localparam logic [CAW-1:0] CT_LAST = CAW'(NUM_CLAUSES - 1);
  localparam logic [TCW-1:0] T_MAX   = TCW'(TIMEOUT_CYCLES);

  state_t         state;
  logic [CAW-1:0] idx;

  assign vt_data_o = 1'b0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      idx            <= '0;
      clause_ready_o <= 1'b0;
      vt_en_o        <= 1'b0;
      vt_wr_en_o     <= 1'b0;
      vt_addr_o      <= '0;
      ct_wr_en_o     <= 1'b0;
      ct_wr_addr_o   <= '0;
      ct_wr_clause_o <= '0;
      solver_start_o <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      sat_o          <= 1'b0;
      timeout_o      <= 1'b0;
      overflow_o     <= 1'b0;
      num_clauses_o  <= '0;
      cycle_count_o  <= '0;
    end else if (abort_i) begin
      // Result flags and counters deliberately keep their values across an abort.
      state          <= IDLE;
      clause_ready_o <= 1'b0;
      vt_en_o        <= 1'b0;
      vt_wr_en_o     <= 1'b0;
      vt_addr_o      <= '0;
      ct_wr_en_o     <= 1'b0;
      solver_start_o <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      ct_wr_en_o     <= 1'b0;
      solver_start_o <= 1'b0;
      done_o         <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_start_i) begin
            state         <= CLEAR_VT;
            busy_o        <= 1'b1;
            vt_en_o       <= 1'b1;
            vt_wr_en_o    <= 1'b1;
            vt_addr_o     <= '0;
            idx           <= '0;
            sat_o         <= 1'b0;
            timeout_o     <= 1'b0;
            overflow_o    <= 1'b0;
            num_clauses_o <= '0;
            cycle_count_o <= '0;
          end
        end
        CLEAR_VT: begin
          if (vt_addr_o == VT_LAST) begin
            state          <= LOAD_CT;
            vt_en_o        <= 1'b0;
            vt_wr_en_o     <= 1'b0;
            vt_addr_o      <= '0;
            clause_ready_o <= 1'b1;
          end else begin
            vt_addr_o <= vt_addr_o + 1'b1;
          end
        end
        LOAD_CT: begin
          if (clause_valid_i && clause_ready_o) begin
            ct_wr_en_o     <= 1'b1;
            ct_wr_addr_o   <= idx;
            ct_wr_clause_o <= clause_data_i;
            // A final clause landing in the last slot is a normal load, not an overflow.
            if (clause_last_i) begin
              num_clauses_o  <= (CAW+1)'(idx) + (CAW+1)'(1);
              clause_ready_o <= 1'b0;
              state          <= START;
            end else if (idx == CT_LAST) begin
              num_clauses_o  <= (CAW+1)'(idx) + (CAW+1)'(1);
              overflow_o     <= 1'b1;
              clause_ready_o <= 1'b0;
              state          <= FINISH;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        START: begin
          solver_start_o <= 1'b1;
          state          <= RUN;
        end
        RUN: begin
          if (solver_done_i) begin
            sat_o <= 1'b1;
            state <= FINISH;
          end else if (cycle_count_o == T_MAX) begin
            timeout_o <= 1'b1;
            state     <= FINISH;
          end else begin
            cycle_count_o <= cycle_count_o + 1'b1;
          end
        end
        FINISH: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
